// File: rtl/ecg_acq_sequencer_if.sv
// Signal bundle between the acquisition sequencer and its surroundings
// (control, FIFO/ADC fetch paths, tagged sample stream, status).
interface ecg_acq_sequencer_if #(
    parameter int NCH        = 2,
    parameter int DATA_WIDTH = 16,
    parameter int CTR_WIDTH  = 32
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic                      i_en;
    logic [NCH-1:0]            i_src_sel;
    logic                      i_new_record;
    logic                      i_clr_status;
    logic [NCH-1:0]            o_fifo_pop;
    logic [NCH*DATA_WIDTH-1:0] i_fifo_data;
    logic [NCH-1:0]            i_fifo_empty;
    logic [NCH-1:0]            i_fifo_rd_valid;
    logic                      o_adc_convst;
    logic [CH_W-1:0]           o_adc_ch;
    logic [DATA_WIDTH-1:0]     i_adc_data;
    logic                      i_adc_rd_valid;
    logic [DATA_WIDTH-1:0]     o_sample;
    logic [CH_W-1:0]           o_sample_ch;
    logic                      o_sample_valid;
    logic                      o_sample_stale;
    logic [CTR_WIDTH-1:0]      o_ctr;
    logic                      o_frame_done;
    logic                      o_overrun;
    logic                      o_adc_timeout;
    logic [2:0]                o_state;

    // Handshakes: every strobe (pop, convst, rd_valid, sample_valid) is a
    // single-cycle pulse with no backpressure; the receiver must take it in
    // the cycle it is high, and data fields are only meaningful in that cycle.
    modport master (
        input  i_en, i_src_sel, i_new_record, i_clr_status,
        input  i_fifo_data, i_fifo_empty, i_fifo_rd_valid,
        input  i_adc_data, i_adc_rd_valid,
        output o_fifo_pop, o_adc_convst, o_adc_ch,
        output o_sample, o_sample_ch, o_sample_valid, o_sample_stale,
        output o_ctr, o_frame_done, o_overrun, o_adc_timeout, o_state
    );

    modport slave (
        output i_en, i_src_sel, i_new_record, i_clr_status,
        output i_fifo_data, i_fifo_empty, i_fifo_rd_valid,
        output i_adc_data, i_adc_rd_valid,
        input  o_fifo_pop, o_adc_convst, o_adc_ch,
        input  o_sample, o_sample_ch, o_sample_valid, o_sample_stale,
        input  o_ctr, o_frame_done, o_overrun, o_adc_timeout, o_state
    );
endinterface

// File: rtl/ecg_acq_sequencer.sv
// Multi-channel acquisition sequencer: internal rate tick, per-frame channel
// walk fetching from ADC or replay FIFO, tagged sample stream and sticky status.
module ecg_acq_sequencer #(
    parameter int NCH         = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int CTR_WIDTH   = 32,
    parameter int TICK_DIV    = 277778,
    parameter int ADC_TIMEOUT = 1024
) (
    input logic i_clk,
    input logic i_rst,
    ecg_acq_sequencer_if.master bus
);
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W   = $clog2(ADC_TIMEOUT + 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NCH - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ADC_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, CH_START, ADC_WAIT, FIFO_WAIT, EMIT} state_t;
    typedef enum logic [1:0] {K_ADC, K_FIFO, K_EMPTY} kind_t;

    state_t                  state;
    kind_t                   kind;
    logic [TICK_W-1:0]       tick_cnt;
    logic [TO_W-1:0]         to_cnt;
    logic [CH_W-1:0]         ch;
    logic [NCH-1:0]          src_q;
    logic [DATA_WIDTH-1:0]   held [NCH];

    logic [NCH-1:0]          pop_q;
    logic                    convst_q;
    logic [CH_W-1:0]         adc_ch_q;
    logic [DATA_WIDTH-1:0]   sample_q;
    logic [CH_W-1:0]         sample_ch_q;
    logic                    sample_valid_q;
    logic                    sample_stale_q;
    logic [CTR_WIDTH-1:0]    ctr_q;
    logic                    frame_done_q;
    logic                    overrun_q;
    logic                    adc_timeout_q;

    logic                    tick;
    logic                    ovr_tick;
    logic                    emit_last;
    logic                    go_start;
    logic [CH_W-1:0]         nxt_ch;
    logic                    nxt_src;
    logic                    nxt_empty;
    logic                    go_emit;
    logic                    emit_stale;
    logic                    adc_to_evt;
    logic [DATA_WIDTH-1:0]   emit_data;
    logic [CTR_WIDTH-1:0]    ctr_step;

    always_comb begin
        tick      = bus.i_en && (tick_cnt == TICK_LAST) && !bus.i_new_record;
        ovr_tick  = tick && (state != IDLE);
        emit_last = (state == EMIT) && (ch == CH_LAST);
        go_start  = ((state == IDLE) && tick) || ((state == EMIT) && !emit_last);
        // Channel about to enter CH_START; its source is decided one cycle
        // early so convst/pop can be registered strobes.
        nxt_ch    = (state == IDLE) ? '0 : ch + CH_W'(1);
        nxt_src   = (state == IDLE) ? bus.i_src_sel[0] : src_q[nxt_ch];
        nxt_empty = bus.i_fifo_empty[nxt_ch];
        ctr_step  = CTR_WIDTH'(emit_last) + CTR_WIDTH'(ovr_tick);

        go_emit    = 1'b0;
        emit_stale = 1'b0;
        adc_to_evt = 1'b0;
        emit_data  = bus.i_fifo_data[ch*DATA_WIDTH +: DATA_WIDTH];
        case (state)
            CH_START: if (kind == K_EMPTY) begin
                go_emit    = 1'b1;
                emit_stale = 1'b1;
            end
            ADC_WAIT: if (bus.i_adc_rd_valid) begin
                go_emit   = 1'b1;
                emit_data = bus.i_adc_data;
            end else if (to_cnt == TO_LAST) begin
                go_emit    = 1'b1;
                emit_stale = 1'b1;
                adc_to_evt = 1'b1;
            end
            FIFO_WAIT: go_emit = bus.i_fifo_rd_valid[ch];
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            kind           <= K_ADC;
            tick_cnt       <= '0;
            to_cnt         <= '0;
            ch             <= '0;
            src_q          <= '0;
            for (int i = 0; i < NCH; i++) held[i] <= '0;
            pop_q          <= '0;
            convst_q       <= 1'b0;
            adc_ch_q       <= '0;
            sample_q       <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            sample_stale_q <= 1'b0;
            ctr_q          <= '0;
            frame_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
            adc_timeout_q  <= 1'b0;
        end else begin
            pop_q          <= '0;
            convst_q       <= 1'b0;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            // Sticky flags: a set event in the same cycle beats the clear.
            overrun_q     <= ovr_tick || (overrun_q && !bus.i_clr_status);
            adc_timeout_q <= (adc_to_evt && !bus.i_new_record) ||
                             (adc_timeout_q && !bus.i_clr_status);

            if (bus.i_new_record) begin
                state    <= IDLE;
                tick_cnt <= '0;
                ctr_q    <= '0;
                for (int i = 0; i < NCH; i++) held[i] <= '0;
            end else begin
                if (!bus.i_en || tick_cnt == TICK_LAST) tick_cnt <= '0;
                else                                    tick_cnt <= tick_cnt + TICK_W'(1);
                // A dropped tick still advances the index to keep the time axis.
                ctr_q <= ctr_q + ctr_step;

                case (state)
                    IDLE: if (tick) begin
                        src_q <= bus.i_src_sel;
                        state <= CH_START;
                    end
                    CH_START: begin
                        case (kind)
                            K_ADC: begin
                                to_cnt <= TO_W'(1);
                                state  <= ADC_WAIT;
                            end
                            K_FIFO:  state <= FIFO_WAIT;
                            default: state <= EMIT;
                        endcase
                    end
                    ADC_WAIT: if (go_emit) state <= EMIT;
                              else         to_cnt <= to_cnt + TO_W'(1);
                    FIFO_WAIT: if (go_emit) state <= EMIT;
                    EMIT: state <= emit_last ? IDLE : CH_START;
                    default: state <= IDLE;
                endcase

                if (go_start) begin
                    ch <= nxt_ch;
                    if (!nxt_src) begin
                        convst_q <= 1'b1;
                        adc_ch_q <= nxt_ch;
                        kind     <= K_ADC;
                    end else if (!nxt_empty) begin
                        pop_q[nxt_ch] <= 1'b1;
                        kind          <= K_FIFO;
                    end else begin
                        kind <= K_EMPTY;
                    end
                end

                if (go_emit) begin
                    sample_valid_q <= 1'b1;
                    sample_ch_q    <= ch;
                    sample_stale_q <= emit_stale;
                    frame_done_q   <= (ch == CH_LAST);
                    sample_q       <= emit_stale ? held[ch] : emit_data;
                    if (!emit_stale) held[ch] <= emit_data;
                end
            end
        end
    end

    assign bus.o_fifo_pop     = pop_q;
    assign bus.o_adc_convst   = convst_q;
    assign bus.o_adc_ch       = adc_ch_q;
    assign bus.o_sample       = sample_q;
    assign bus.o_sample_ch    = sample_ch_q;
    assign bus.o_sample_valid = sample_valid_q;
    assign bus.o_sample_stale = sample_stale_q;
    assign bus.o_ctr          = ctr_q;
    assign bus.o_frame_done   = frame_done_q;
    assign bus.o_overrun      = overrun_q;
    assign bus.o_adc_timeout  = adc_timeout_q;
    assign bus.o_state        = state;
endmodule
